// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment constants and scan state type for the 7-segment scan controller
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // {a,b,c,d,e,f,g} patterns for BCD 0..9, active-high
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/bcd7_dec.sv
// rtl/bcd7_dec.sv - combinational BCD to 7-segment decoder; non-BCD nibbles decode dark
module bcd7_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - N-digit multiplexed 7-segment scan controller with pending-load slot
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int DWELL     = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [4*N_DIG-1:0] ld_data,
  output logic [6:0]         seg,
  output logic [N_DIG-1:0]   dig_n,
  output logic               frame_done
);

  localparam int DW = ($clog2(DWELL + 1) > 1) ? $clog2(DWELL + 1) : 1;
  localparam int BW = ($clog2(BLANK_CYC + 1) > 1) ? $clog2(BLANK_CYC + 1) : 1;
  localparam int IW = $clog2(N_DIG);
  localparam logic [N_DIG-1:0] ONE_HOT0 = {{(N_DIG-1){1'b0}}, 1'b1};

  scan_state_e        state, nstate;
  logic [IW-1:0]      idx, nidx, idx_inc;
  logic [DW-1:0]      dcnt, ndcnt;
  logic [BW-1:0]      bcnt, nbcnt;
  logic [4*N_DIG-1:0] pend, disp, disp_nxt;
  logic               pend_full, transfer, nfd, lz;
  logic [6:0]         dec_seg;

  assign ld_ready = ~pend_full;
  assign idx_inc  = (idx == IW'(N_DIG - 1)) ? '0 : idx + 1'b1;
  assign transfer = pend_full && (frame_done || state == IDLE);
  // Outputs are registered from next-state values, so decode sees disp as it will be next cycle
  assign disp_nxt = transfer ? pend : disp;

  always_comb begin
    nstate = state;
    nidx   = idx;
    ndcnt  = dcnt;
    nbcnt  = bcnt;
    if (!en) begin
      nstate = IDLE;
      nidx   = '0;
      ndcnt  = '0;
      nbcnt  = '0;
    end else begin
      case (state)
        IDLE: begin
          nstate = SCAN;
          nidx   = '0;
          ndcnt  = '0;
        end
        SCAN: begin
          if (dcnt == DW'(DWELL - 1)) begin
            ndcnt = '0;
            if (BLANK_CYC == 0) begin
              nidx = idx_inc;
            end else begin
              nstate = BLANK;
              nbcnt  = '0;
            end
          end else begin
            ndcnt = dcnt + 1'b1;
          end
        end
        BLANK: begin
          if (bcnt == BW'(BLANK_CYC - 1)) begin
            nstate = SCAN;
            nidx   = idx_inc;
            nbcnt  = '0;
          end else begin
            nbcnt = bcnt + 1'b1;
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    nfd = 1'b0;
    if (nidx == IW'(N_DIG - 1)) begin
      if (BLANK_CYC == 0) nfd = (nstate == SCAN) && (ndcnt == DW'(DWELL - 1));
      else                nfd = (nstate == BLANK) && (nbcnt == BW'(BLANK_CYC - 1));
    end
  end

`ifdef SEG_SCAN_LZB_EN
  assign lz = (nidx != '0) && ((disp_nxt >> {nidx, 2'b00}) == '0);
`else
  assign lz = 1'b0;
`endif

  bcd7_dec u_dec (
    .nib (disp_nxt[{nidx, 2'b00} +: 4]),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      dcnt       <= '0;
      bcnt       <= '0;
      pend       <= '0;
      disp       <= '0;
      pend_full  <= 1'b0;
      seg        <= SEG_BLANK;
      dig_n      <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= nstate;
      idx        <= nidx;
      dcnt       <= ndcnt;
      bcnt       <= nbcnt;
      frame_done <= nfd;
      dig_n      <= (nstate == SCAN) ? ~(ONE_HOT0 << nidx) : '1;
      seg        <= (nstate == SCAN && !lz) ? dec_seg : SEG_BLANK;
      if (transfer) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (ld_valid && !pend_full) begin
        pend      <= ld_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (N_DIG=4, DWELL=4, BLANK_CYC=2)
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int DWELL = 4;
  localparam int BL = 2;
  localparam int SLOT = DWELL + BL;
  localparam int FRAME = N * SLOT;

  logic        clk, rst_n, en, ld_valid, ld_ready, frame_done;
  logic [15:0] ld_data;
  logic [6:0]  seg;
  logic [3:0]  dig_n;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl #(.N_DIG(N), .DWELL(DWELL), .BLANK_CYC(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .seg        (seg),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: time since scan start plus the displayed/pending words
  bit          m_run, m_full;
  int          m_t;
  logic [15:0] m_disp, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_full = 0; m_t = 0; m_disp = 0; m_pend = 0;
    end else begin
      if (m_full && (!m_run || (m_t % FRAME == FRAME - 1))) begin
        m_disp = m_pend;
        m_full = 0;
      end else if (ld_valid && !m_full) begin
        m_pend = ld_data;
        m_full = 1;
      end
      m_t   = (m_run && en) ? m_t + 1 : 0;
      m_run = en;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [3:0] ed = 4'hF;
      automatic logic [6:0] es = 7'b0;
      automatic logic       ef = 1'b0;
      automatic int d = (m_t / SLOT) % N;
      automatic int ph = m_t % SLOT;
      if (m_run) begin
        ef = (m_t % FRAME == FRAME - 1);
        if (ph < DWELL) begin
          ed = ~(4'b0001 << d);
          es = dec(m_disp[4*d +: 4]);
`ifdef SEG_SCAN_LZB_EN
          if (d > 0 && (m_disp >> (4*d)) == 16'h0) es = 7'b0;
`endif
        end
      end
      tests++;
      if (dig_n !== ed || seg !== es || frame_done !== ef || ld_ready !== !m_full) begin
        fails++;
        $display("FAIL model t=%0d: dig_n=%b seg=%b fd=%b rdy=%b want dig_n=%b seg=%b fd=%b rdy=%b",
                 m_t, dig_n, seg, frame_done, ld_ready, ed, es, ef, !m_full);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after acceptance with ld_valid low
  task automatic load(input logic [15:0] v);
    int k = 0;
    ld_data = v;
    ld_valid = 1;
    while (!ld_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ld_accept", {31'b0, ld_ready}, 1);
    go(1);
    ld_valid = 0;
  endtask

  task automatic wait_fd();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 100);
    chk("fd_wait", {31'b0, frame_done}, 1);
  endtask

  logic [3:0] exp_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};

  initial begin
    rst_n = 0; en = 0; ld_valid = 0; ld_data = 0;
    go(1);
    chk("rst_seg", seg, 0);
    chk("rst_dig", dig_n, 4'hF);
    chk("rst_rdy", ld_ready, 1);
    go(1);
    rst_n = 1;
    go(1);

    load(16'h1234);
    go(2);
    en = 1;
    for (int c = 0; c < FRAME; c++) begin
      go(1);
      if (c % SLOT < DWELL) begin
        chk($sformatf("f1_dig c%0d", c), dig_n, exp_dig[c / SLOT]);
        chk($sformatf("f1_seg c%0d", c), seg, exp_seg[c / SLOT]);
      end else begin
        chk($sformatf("f1_dark c%0d", c), {dig_n, seg}, {4'hF, 7'b0});
      end
      chk($sformatf("f1_fd c%0d", c), frame_done, c == FRAME - 1);
    end

    go(9);
    load(16'h5678);
    chk("pend_rdy_low", ld_ready, 0);
    ld_valid = 1; ld_data = 16'h9999;
    go(1);
    ld_valid = 0;
    chk("pend_rdy_low2", ld_ready, 0);
    wait_fd();
    chk("rdy_at_fd", ld_ready, 0);
    go(1);
    chk("rdy_after", ld_ready, 1);
    chk("5678_d0", {dig_n, seg}, {4'b1110, 7'b1111111});
    go(18);
    chk("5678_d3", {dig_n, seg}, {4'b0111, 7'b1011011});

    load(16'h00A9);
    wait_fd();
    go(1);
    chk("a9_d0", {dig_n, seg}, {4'b1110, 7'b1111011});
    go(6);
    chk("a9_d1", {dig_n, seg}, {4'b1101, 7'b0000000});

    load(16'h0070);
    wait_fd();
    go(1);
    chk("70_d0", {dig_n, seg}, {4'b1110, 7'b1111110});
    go(6);
    chk("70_d1", {dig_n, seg}, {4'b1101, 7'b1110000});
    go(6);
`ifdef SEG_SCAN_LZB_EN
    chk("70_d2", {dig_n, seg}, {4'b1011, 7'b0000000});
`else
    chk("70_d2", {dig_n, seg}, {4'b1011, 7'b1111110});
`endif
    go(6);
`ifdef SEG_SCAN_LZB_EN
    chk("70_d3", {dig_n, seg}, {4'b0111, 7'b0000000});
`else
    chk("70_d3", {dig_n, seg}, {4'b0111, 7'b1111110});
`endif

    wait_fd();
    go(14);
    chk("en_d2", dig_n, 4'b1011);
    en = 0;
    go(1);
    chk("en_off", {dig_n, seg, frame_done}, {4'hF, 7'b0, 1'b0});
    go(2);
    en = 1;
    go(1);
    chk("en_on_d0", {dig_n, seg}, {4'b1110, 7'b1111110});
    go(3);
    chk("en_on_c3", dig_n, 4'b1110);
    go(1);
    chk("en_on_c4", dig_n, 4'hF);

    go(3);
    chk("pre_rst", dig_n, 4'b1101);
    #3 rst_n = 0;
    #1;
    chk("arst_seg", seg, 0);
    chk("arst_dig", dig_n, 4'hF);
    chk("arst_rdy", ld_ready, 1);
    chk("arst_fd", frame_done, 0);
    go(2);
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) en = ~en;
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_data  = 16'($urandom);
    end
    ld_valid = 0;
    go(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
